// File: rtl/axi_lite_slave_ext.sv
// axi_lite_slave_ext: AXI4-Lite slave that bridges one AXI4-Lite port onto a
// simple unit read/write request interface.
//
// Write path: AW and W are accepted independently, in either order. Once both
// are held, the captured word address, data, byte strobes and protection bits
// are presented to the unit with unit_wen held high until unit_wack or a
// timeout. A write with all strobes clear is answered OKAY without touching
// the unit.
// Read path: AR is accepted, then unit_ren is held high until unit_rstrb or a
// timeout. The read path is fully independent of the write path.
// A unit that never answers is turned into an SLVERR response after
// TIMEOUT_CYCLES cycles (0 disables the timeout).
//
// Ports:
//   s_axi_aclk, s_axi_areset   clock, synchronous active-high reset
//   s_axi_aw*/w*/b*            AXI4-Lite write address / data / response
//   s_axi_ar*/r*               AXI4-Lite read address / data
//   unit_wen/waddr/wdata/wstrb/wprot, unit_wack, unit_invalid_waddr
//                              unit write request and completion
//   unit_ren/raddr/rprot, unit_rstrb, unit_rdata, unit_invalid_raddr
//                              unit read request and completion
module axi_lite_slave_ext #(
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int SLV_ADDR_WIDTH = AXI_ADDR_WIDTH - $clog2(STROBE_WIDTH),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [STROBE_WIDTH-1:0]   s_axi_wstrb,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      unit_wen,
    output logic [SLV_ADDR_WIDTH-1:0] unit_waddr,
    output logic [DATA_WIDTH-1:0]     unit_wdata,
    output logic [STROBE_WIDTH-1:0]   unit_wstrb,
    output logic [2:0]                unit_wprot,
    input  logic                      unit_wack,
    input  logic                      unit_invalid_waddr,
    output logic                      unit_ren,
    output logic [SLV_ADDR_WIDTH-1:0] unit_raddr,
    output logic [2:0]                unit_rprot,
    input  logic                      unit_rstrb,
    input  logic [DATA_WIDTH-1:0]     unit_rdata,
    input  logic                      unit_invalid_raddr
);

    localparam int ADDR_LSB = $clog2(STROBE_WIDTH);
    // A zero-width counter is illegal, so a disabled timeout keeps one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_UNIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_UNIT, R_RESP} r_state_t;

    // Byte-lane bits of the addresses are not part of the unit word address.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    // ---------------- write path ----------------
    w_state_t                  w_state, w_state_n;
    logic                      aw_held, aw_held_n, w_held, w_held_n;
    logic                      awready_n, wready_n, bvalid_n, wen_n;
    logic [1:0]                bresp_n;
    logic [SLV_ADDR_WIDTH-1:0] waddr_n;
    logic [DATA_WIDTH-1:0]     wdata_n;
    logic [STROBE_WIDTH-1:0]   wstrb_n;
    logic [2:0]                wprot_n;
    logic [CNT_W-1:0]          w_cnt, w_cnt_n;
    logic                      aw_hs, w_hs, w_expired;

    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign w_expired = (TIMEOUT_CYCLES != 0) && (w_cnt == CNT_LAST);

    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        awready_n = s_axi_awready;
        wready_n  = s_axi_wready;
        bvalid_n  = s_axi_bvalid;
        bresp_n   = s_axi_bresp;
        wen_n     = unit_wen;
        waddr_n   = unit_waddr;
        wdata_n   = unit_wdata;
        wstrb_n   = unit_wstrb;
        wprot_n   = unit_wprot;
        w_cnt_n   = w_cnt;
        case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_n = 1'b1;
                    waddr_n   = s_axi_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
                    wprot_n   = s_axi_awprot;
                end
                if (w_hs) begin
                    w_held_n = 1'b1;
                    wdata_n  = s_axi_wdata;
                    wstrb_n  = s_axi_wstrb;
                end
                awready_n = !aw_held_n;
                wready_n  = !w_held_n;
                if (aw_held_n && w_held_n) begin
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    // An all-zero strobe changes nothing, so skip the unit.
                    if (wstrb_n == '0) begin
                        bvalid_n  = 1'b1;
                        bresp_n   = RESP_OKAY;
                        w_state_n = W_RESP;
                    end else begin
                        wen_n     = 1'b1;
                        w_cnt_n   = '0;
                        w_state_n = W_UNIT;
                    end
                end
            end
            W_UNIT: begin
                w_cnt_n = w_cnt + 1'b1;
                // Ack is checked first so an ack in the expiry cycle still wins.
                if (unit_wack) begin
                    wen_n     = 1'b0;
                    bvalid_n  = 1'b1;
                    bresp_n   = unit_invalid_waddr ? RESP_DECERR : RESP_OKAY;
                    w_state_n = W_RESP;
                end else if (w_expired) begin
                    wen_n     = 1'b0;
                    bvalid_n  = 1'b1;
                    bresp_n   = RESP_SLVERR;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_n  = 1'b0;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state       <= W_IDLE;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            unit_wen      <= 1'b0;
            unit_waddr    <= '0;
            unit_wdata    <= '0;
            unit_wstrb    <= '0;
            unit_wprot    <= 3'b000;
            w_cnt         <= '0;
        end else begin
            w_state       <= w_state_n;
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            s_axi_awready <= awready_n;
            s_axi_wready  <= wready_n;
            s_axi_bvalid  <= bvalid_n;
            s_axi_bresp   <= bresp_n;
            unit_wen      <= wen_n;
            unit_waddr    <= waddr_n;
            unit_wdata    <= wdata_n;
            unit_wstrb    <= wstrb_n;
            unit_wprot    <= wprot_n;
            w_cnt         <= w_cnt_n;
        end
    end

    // ---------------- read path ----------------
    r_state_t                  r_state, r_state_n;
    logic                      arready_n, rvalid_n, ren_n;
    logic [1:0]                rresp_n;
    logic [DATA_WIDTH-1:0]     rdata_n;
    logic [SLV_ADDR_WIDTH-1:0] raddr_n;
    logic [2:0]                rprot_n;
    logic [CNT_W-1:0]          r_cnt, r_cnt_n;
    logic                      r_expired;

    assign r_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        r_state_n = r_state;
        arready_n = s_axi_arready;
        rvalid_n  = s_axi_rvalid;
        rresp_n   = s_axi_rresp;
        rdata_n   = s_axi_rdata;
        ren_n     = unit_ren;
        raddr_n   = unit_raddr;
        rprot_n   = unit_rprot;
        r_cnt_n   = r_cnt;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (s_axi_arvalid && s_axi_arready) begin
                    arready_n = 1'b0;
                    ren_n     = 1'b1;
                    raddr_n   = s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
                    rprot_n   = s_axi_arprot;
                    r_cnt_n   = '0;
                    r_state_n = R_UNIT;
                end
            end
            R_UNIT: begin
                r_cnt_n = r_cnt + 1'b1;
                if (unit_rstrb) begin
                    ren_n     = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = unit_rdata;
                    rresp_n   = unit_invalid_raddr ? RESP_DECERR : RESP_OKAY;
                    r_state_n = R_RESP;
                end else if (r_expired) begin
                    ren_n     = 1'b0;
                    rvalid_n  = 1'b1;
                    rdata_n   = '0;
                    rresp_n   = RESP_SLVERR;
                    r_state_n = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
            unit_ren      <= 1'b0;
            unit_raddr    <= '0;
            unit_rprot    <= 3'b000;
            r_cnt         <= '0;
        end else begin
            r_state       <= r_state_n;
            s_axi_arready <= arready_n;
            s_axi_rvalid  <= rvalid_n;
            s_axi_rresp   <= rresp_n;
            s_axi_rdata   <= rdata_n;
            unit_ren      <= ren_n;
            unit_raddr    <= raddr_n;
            unit_rprot    <= rprot_n;
            r_cnt         <= r_cnt_n;
        end
    end

endmodule

// File: doc/axi_lite_slave_ext.md
Name: axi_lite_slave_ext

Overview:
AXI4-Lite slave-to-unit bridge and the parametrised successor of the team's basic AXI-Lite slave. It terminates one AXI4-Lite port and drives a simple unit read/write strobe interface. New relative to the basic slave:
- AW and W accepted independently, in either order.
- Byte strobes and protection bits forwarded to the unit.
- A per-transaction timeout that converts a hung unit into SLVERR.
- Zero-strobe write short-circuit.
Sits between the AXI interconnect and each peripheral register block.

Parameters:
DATA_WIDTH, 32, AXI/unit data width; multiple of 8, at least 32
STROBE_WIDTH, DATA_WIDTH/8, byte lanes
AXI_ADDR_WIDTH, 16, AXI byte-address width
SLV_ADDR_WIDTH, AXI_ADDR_WIDTH-$clog2(STROBE_WIDTH), unit word-address width
TIMEOUT_CYCLES, 256, cycles to wait for unit ack/strobe; 0 disables the timeout

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  reset, synchronous, active-high
s_axi_awvalid/s_axi_awready  in/out  1  write-address handshake
s_axi_awaddr  in  AXI_ADDR_WIDTH  write byte address
s_axi_awprot  in  3  write protection
s_axi_wvalid/s_axi_wready  in/out  1  write-data handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STROBE_WIDTH  byte strobes
s_axi_bvalid/s_axi_bready  out/in  1  write-response handshake
s_axi_bresp  out  2  write response
s_axi_arvalid/s_axi_arready  in/out  1  read-address handshake
s_axi_araddr  in  AXI_ADDR_WIDTH  read byte address
s_axi_arprot  in  3  read protection
s_axi_rvalid/s_axi_rready  out/in  1  read-data handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
unit_wen  out  1  write request, level, held until ack or timeout
unit_waddr  out  SLV_ADDR_WIDTH  word address
unit_wdata  out  DATA_WIDTH  write data
unit_wstrb  out  STROBE_WIDTH  byte enables
unit_wprot  out  3  captured awprot
unit_wack  in  1  write complete
unit_invalid_waddr  in  1  qualifies unit_wack: address invalid
unit_ren  out  1  read request, level, held until strobe or timeout
unit_raddr  out  SLV_ADDR_WIDTH  word address
unit_rprot  out  3  captured arprot
unit_rstrb  in  1  read data valid
unit_rdata  in  DATA_WIDTH  read data
unit_invalid_raddr  in  1  qualifies unit_rstrb: address invalid

Behaviour:
- Reset values:
  - All outputs 0, both FSMs in IDLE, held flags and timeout counters cleared.
  - Reset asserted mid-transaction abandons it: no response is issued, and unit_wen/unit_ren drop at the same edge.
- Response codes: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- Unit word address = byte address [AXI_ADDR_WIDTH-1:$clog2(STROBE_WIDTH)]; low bits are ignored.
- Write FSM, W_IDLE -> W_UNIT -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1 while no AW is held; wready=1 while no W is held. Both are registered and go 1 the cycle after reset release.
  - Each handshake captures its channel and drops that ready on the next edge.
  - Once both channels are held (same-cycle handshakes allowed), the next edge enters W_UNIT with unit_wen=1 and addr/data/strb/prot presented.
  - Zero strobes (wstrb==0): unit_wen is not asserted; go directly to W_RESP with bresp=OKAY.
  - W_UNIT: the timeout counter increments each cycle.
  - W_UNIT, unit_wack=1: the next edge sets unit_wen=0, bvalid=1, bresp=DECERR if unit_invalid_waddr else OKAY.
  - W_UNIT, no ack after TIMEOUT_CYCLES cycles: unit_wen=0, bvalid=1, bresp=SLVERR. If the ack arrives in the same cycle as expiry, the ack wins.
  - unit_wack is ignored outside W_UNIT.
  - W_RESP: bvalid/bresp are held stable until bready. The handshake edge returns to W_IDLE with held flags cleared; awready/wready are 1 on the following cycle.
- Latency: AW+W handshake at edge N -> unit_wen high after N; unit_wack sampled at edge M -> bvalid high after M.
- Read FSM, R_IDLE -> R_UNIT -> R_RESP, fully independent of the write FSM:
  - R_IDLE: arready=1; handshake -> R_UNIT with unit_ren=1 and raddr/rprot presented.
  - R_UNIT, unit_rstrb=1: capture rdata into s_axi_rdata, rresp=DECERR or OKAY, unit_ren=0, rvalid=1.
  - R_UNIT timeout: rdata=0, rresp=SLVERR.
  - R_RESP: rdata/rresp held until rready, then back to R_IDLE.
- Simultaneous read and write are allowed; each channel has its own unit port, and ordering between them is not guaranteed.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). Counter is reset on entry to each UNIT state.

Test Plan:
1. AW at cycle 5, W at cycle 9, awaddr=0x0010, wdata=0xDEADBEEF, wstrb=4'b0011 -> unit_wen after W handshake, waddr=0x0004, wstrb=0011; unit_wack 2 cycles later -> bresp=OKAY.
2. W before AW, and AW+W in the same cycle -> one unit write each; bvalid held 4 cycles with bready=0 and bresp stable; next AW accepted only after B handshake.
3. Read araddr=0x0020, unit_rstrb with unit_invalid_raddr=1, rdata=0x12345678 -> raddr=0x0008, rresp=DECERR, rdata=0x12345678.
4. TIMEOUT_CYCLES=8, unit never acks a write -> unit_wen drops, bresp=SLVERR after 8 cycles in W_UNIT. Repeat for a read -> rresp=SLVERR, rdata=0. Ack coincident with expiry -> OKAY.
5. wstrb=0 write -> no unit_wen pulse, bresp=OKAY; concurrent read and write both complete correctly.
6. s_axi_areset asserted while unit_wen=1 and rvalid=1 -> all outputs 0 next edge, no bvalid; after release a clean write completes with OKAY.
